// File: rtl/rider_alert.sv
// Rider presence/balance, battery and over-speed alerts for a self-balancing platform.
// Define RIDER_ALERT_BATT_LATCH_EN to make batt_low sticky until reset.
module rider_alert #(
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040,
  parameter logic [11:0] BATT_THRES   = 12'h800,
  parameter logic [11:0] BATT_HYST    = 12'h020,
  parameter logic [11:0] SPD_THRES    = 12'h600,
  parameter logic [11:0] SPD_HYST     = 12'h040,
  parameter int          FAST_SIM     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic [11:0] batt,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  output logic        en_steer,
  output logic        rider_off,
  output logic        batt_low,
  output logic        too_fast
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [25:0] timer_q, timer_d;
  logic        en_steer_q, en_steer_d;
  logic        rider_off_q, rider_off_d;
  logic        batt_low_q, batt_low_d;
  logic        too_fast_q, too_fast_d;

  logic [12:0] sum;
  logic [11:0] diff;
  logic [16:0] sum_w;
  logic [16:0] diff_w;
  logic        rider_on;
  logic        rider_gone;
  logic        wait_imbal;
  logic        steer_imbal;
  logic        timer_full;
  logic        timer_clr;

  logic [11:0] lft_mag;
  logic [11:0] rght_mag;
  logic [11:0] mag;
  logic        fast_set;
  logic        fast_clr;
  logic        batt_set;
  logic        batt_clr;

  // Two's-complement magnitude; the most negative code has no positive twin, so clamp it.
  function automatic logic [11:0] sat_abs(input logic [11:0] v);
    logic [11:0] r;
    if (!v[11]) begin
      r = v;
    end else if (v == 12'h800) begin
      r = 12'h7FF;
    end else begin
      r = ~v + 12'd1;
    end
    return r;
  endfunction

  always_comb begin
    sum    = {1'b0, lft_ld} + {1'b0, rght_ld};
    diff   = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
    sum_w  = {4'b0000, sum};
    diff_w = {5'b00000, diff};

    rider_on   = sum > {1'b0, MIN_RIDER_WT};
    rider_gone = ({1'b0, sum} + {2'b00, WT_HYST}) < {2'b00, MIN_RIDER_WT};
    wait_imbal = (diff_w << 2) > sum_w;
    // 15*sum as 16*sum-sum; the 17-bit width holds 16*8190 without wrapping.
    steer_imbal = (diff_w << 4) > ((sum_w << 4) - sum_w);

    timer_full = (FAST_SIM != 0) ? (&timer_q[14:0]) : (&timer_q);
  end

  always_comb begin
    state_d   = state_q;
    timer_clr = 1'b0;
    if (vld) begin
      unique case (state_q)
        IDLE: begin
          if (rider_on) begin
            state_d   = WAIT;
            timer_clr = 1'b1;
          end
        end
        WAIT: begin
          if (rider_gone) begin
            state_d = IDLE;
          end else if (wait_imbal) begin
            timer_clr = 1'b1;
          end else if (timer_full) begin
            state_d = STEER;
          end
        end
        STEER: begin
          if (rider_gone) begin
            state_d = IDLE;
          end else if (steer_imbal) begin
            state_d   = WAIT;
            timer_clr = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // The settle timer free-runs on every clock, not just on sample strobes.
    if (timer_clr) begin
      timer_d = 26'd0;
    end else if (timer_full) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 26'd1;
    end
  end

  always_comb begin
    lft_mag  = sat_abs(lft_spd);
    rght_mag = sat_abs(rght_spd);
    mag      = (lft_mag >= rght_mag) ? lft_mag : rght_mag;

    fast_set = mag > SPD_THRES;
    fast_clr = ({1'b0, mag} + {1'b0, SPD_HYST}) <= {1'b0, SPD_THRES};
    batt_set = batt < BATT_THRES;
    batt_clr = {1'b0, batt} >= ({1'b0, BATT_THRES} + {1'b0, BATT_HYST});
  end

  // Alarm flags only move on sample strobes; set is checked first so it dominates clear.
  always_comb begin
    en_steer_d  = en_steer_q;
    rider_off_d = rider_off_q;
    batt_low_d  = batt_low_q;
    too_fast_d  = too_fast_q;
    if (vld) begin
      en_steer_d  = (state_d == STEER);
      rider_off_d = (state_d == IDLE);

      if (fast_set) begin
        too_fast_d = 1'b1;
      end else if (fast_clr) begin
        too_fast_d = 1'b0;
      end

      if (batt_set) begin
        batt_low_d = 1'b1;
      end else if (batt_clr) begin
`ifdef RIDER_ALERT_BATT_LATCH_EN
        batt_low_d = batt_low_q;
`else
        batt_low_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= 26'd0;
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b1;
      batt_low_q  <= 1'b0;
      too_fast_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      en_steer_q  <= en_steer_d;
      rider_off_q <= rider_off_d;
      batt_low_q  <= batt_low_d;
      too_fast_q  <= too_fast_d;
    end
  end

  assign en_steer  = en_steer_q;
  assign rider_off = rider_off_q;
  assign batt_low  = batt_low_q;
  assign too_fast  = too_fast_q;

endmodule

// File: tb/tb_rider_alert.sv
// Scoreboard bench for rider_alert: a behavioural model queues the expected
// {en_steer, rider_off, batt_low, too_fast} per driven cycle, compared after the edge.
module tb_rider_alert;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic [11:0] lft_ld = '0;
  logic [11:0] rght_ld = '0;
  logic [11:0] batt = 12'hFFF;
  logic [11:0] lft_spd = '0;
  logic [11:0] rght_spd = '0;
  logic        en_steer;
  logic        rider_off;
  logic        batt_low;
  logic        too_fast;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  logic [3:0] expQ[$];
  string      tagQ[$];

  int m_state = 0;
  int m_timer = 0;
  bit m_en = 1'b0;
  bit m_off = 1'b1;
  bit m_bl = 1'b0;
  bit m_tf = 1'b0;

  rider_alert dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld      (vld),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .batt     (batt),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .en_steer (en_steer),
    .rider_off(rider_off),
    .batt_low (batt_low),
    .too_fast (too_fast)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int spdMag(input logic [11:0] s);
    int v;
    v = $signed(s);
    if (v < 0) v = -v;
    if (v > 2047) v = 2047;
    return v;
  endfunction

  // Drives one cycle, advances the model, and optionally scores the post-edge outputs.
  task automatic applyStimulus(input string tag, input bit chk, input logic r, input logic v,
                               input logic [11:0] l, input logic [11:0] rr, input logic [11:0] b,
                               input logic [11:0] ls, input logic [11:0] rs);
    int sum;
    int diff;
    int ns;
    int mag;
    bit clr;
    bit full;
    logic [3:0] e;
    string t;
    @(negedge clk);
    rst_n = r; vld = v; lft_ld = l; rght_ld = rr; batt = b; lft_spd = ls; rght_spd = rs;
    if (!r) begin
      m_state = 0; m_timer = 0; m_en = 0; m_off = 1; m_bl = 0; m_tf = 0;
    end else begin
      sum  = int'(l) + int'(rr);
      diff = (l >= rr) ? int'(l) - int'(rr) : int'(rr) - int'(l);
      full = (m_timer == 32767);
      ns   = m_state;
      clr  = 0;
      if (v) begin
        if (m_state == 0) begin
          if (sum > 512) begin ns = 1; clr = 1; end
        end else if (m_state == 1) begin
          if (sum < 448) ns = 0;
          else if (4 * diff > sum) clr = 1;
          else if (full) ns = 2;
        end else begin
          if (sum < 448) ns = 0;
          else if (16 * diff > 15 * sum) begin ns = 1; clr = 1; end
        end
      end
      m_timer = clr ? 0 : (full ? m_timer : m_timer + 1);
      if (v) begin
        m_state = ns;
        m_en  = (ns == 2);
        m_off = (ns == 0);
        mag = spdMag(ls);
        if (spdMag(rs) > mag) mag = spdMag(rs);
        if (mag > 1536) m_tf = 1;
        else if (mag <= 1472) m_tf = 0;
        if (int'(b) < 2048) m_bl = 1;
`ifndef RIDER_ALERT_BATT_LATCH_EN
        else if (int'(b) >= 2080) m_bl = 0;
`endif
      end
    end
    if (chk) begin
      expQ.push_back({m_en, m_off, m_bl, m_tf});
      tagQ.push_back(tag);
    end
    @(posedge clk);
    #1;
    cycleNo++;
    if (chk) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkOutput(t, {28'd0, en_steer, rider_off, batt_low, too_fast}, {28'd0, e});
    end
  endtask

  task automatic bal(input string tag, input bit chk, input logic [11:0] w);
    applyStimulus(tag, chk, 1'b1, 1'b1, w, w, 12'hFFF, 12'h000, 12'h000);
  endtask

  // Holds the platform balanced until en_steer rises, then checks the settle latency.
  task automatic waitSteer(input string tag, input int entry, input string midTag);
    int lat;
    bit done;
    done = 0;
    for (int i = 0; i < 33500 && !done; i++) begin
      bal(tag, 1'b0, 12'h180);
      lat = cycleNo - entry;
      if (lat == 32000) checkOutput(midTag, {31'd0, en_steer}, 32'd0);
      if (en_steer === 1'b1) done = 1;
    end
    lat = cycleNo - entry;
    checkOutput(tag, {31'd0, done && lat >= 32767 && lat <= 32770}, 32'd1);
    if (!done) $display("[TB] settle wait expired after %0d cycles", lat);
  endtask

  initial begin
    int entry;
    $display("[TB] rider_alert scoreboard bench start");

    for (int i = 0; i < 3; i++)
      applyStimulus("reset_hold", 1'b1, 1'b0, 1'b1, 12'h180, 12'h180, 12'h7FF, 12'h800, 12'h000);

    applyStimulus("first_vld", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'h7FF, 12'h000, 12'h000);
    entry = cycleNo;
    applyStimulus("batt_810", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'h810, 12'h000, 12'h000);
    applyStimulus("batt_820", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'h820, 12'h000, 12'h000);
    applyStimulus("batt_810_hold", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'h810, 12'h000, 12'h000);
    applyStimulus("batt_fff", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'hFFF, 12'h000, 12'h000);

    applyStimulus("spd_800", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'hFFF, 12'h800, 12'h000);
    applyStimulus("spd_novld_hold", 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000);
    applyStimulus("spd_clear", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'hFFF, 12'h000, 12'h000);
    applyStimulus("spd_neg_at_thres", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'hFFF, 12'h000, 12'hA00);
    applyStimulus("spd_neg_over", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'hFFF, 12'h000, 12'h9FF);
    applyStimulus("spd_hyst_hold", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'hFFF, 12'h000, 12'h5C1);
    applyStimulus("spd_hyst_clear", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'hFFF, 12'h000, 12'h5C0);

    waitSteer("settle_latency_1", entry, "settle_mid_1");
    bal("steer_hold", 1'b1, 12'h180);
    bal("steer_sum_1f0", 1'b1, 12'h0F8);
    applyStimulus("steer_mild_tilt", 1'b1, 1'b1, 1'b1, 12'h1A0, 12'h160, 12'hFFF, 12'h000, 12'h000);

    applyStimulus("steer_tilt_exit", 1'b1, 1'b1, 1'b1, 12'h300, 12'h000, 12'hFFF, 12'h000, 12'h000);
    applyStimulus("wait_tilt_stay", 1'b1, 1'b1, 1'b1, 12'h300, 12'h000, 12'hFFF, 12'h000, 12'h000);
    entry = cycleNo;
    waitSteer("settle_latency_2", entry, "settle_restart_mid");

    applyStimulus("steer_batt_low", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'h700, 12'h000, 12'h000);
    applyStimulus("steer_too_fast", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'h700, 12'h700, 12'h000);
    applyStimulus("steer_sum_1b0", 1'b1, 1'b1, 1'b1, 12'h0D8, 12'h0D8, 12'h700, 12'h700, 12'h000);
    applyStimulus("idle_to_wait", 1'b1, 1'b1, 1'b1, 12'h180, 12'h180, 12'h700, 12'h700, 12'h000);
    applyStimulus("mid_reset", 1'b1, 1'b0, 1'b1, 12'h180, 12'h180, 12'h700, 12'h700, 12'h000);
    bal("post_reset_first", 1'b1, 12'h180);

    bal("wait_sum_1f0", 1'b1, 12'h0F8);
    bal("wait_sum_1b0", 1'b1, 12'h0D8);
    bal("idle_sum_200", 1'b1, 12'h100);
    applyStimulus("idle_sum_201", 1'b1, 1'b1, 1'b1, 12'h101, 12'h100, 12'hFFF, 12'h000, 12'h000);
    applyStimulus("novld_hold", 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 12'h000, 12'h800, 12'h000);
    applyStimulus("wait_light_exit", 1'b1, 1'b1, 1'b1, 12'h180, 12'h000, 12'hFFF, 12'h000, 12'h000);

    if (expQ.size() != 0) checkOutput("scoreboard_drain", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
